// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer slice.
// Package VSTypes is imported by the interface, the in-flight FIFO and the top.
package VSTypes;

    typedef logic [31:0] addr32b;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } PcSeqStateType;

    localparam addr32b PC_STEP       = 32'd4;
    localparam addr32b PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // Word-align an address; every PC leaving the sequencer goes through this.
    function automatic addr32b align_pc(input addr32b raw);
        return raw & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the PC sequencer (master) and the fetch/branch side (slave).
// Carries the PC handshake, skip/redirect inputs, retire pop and stats outputs.
interface pc_sequencer_if #(
    parameter int INFLIGHT_DEPTH = 4,
    parameter int CNT_W          = 16
);
    import VSTypes::*;

    addr32b                        PredictedPCOut;
    logic                          PCValidOut;
    logic                          PCReadyIn;
    logic                          SkipTakenIn;
    addr32b                        SkipTargetIn;
    logic                          RedirectEnIn;
    addr32b                        RedirectPCIn;
    logic                          StallIn;
    logic                          RetireIn;
    addr32b                        RetirePCOut;
    logic [$clog2(INFLIGHT_DEPTH):0] InFlightCntOut;
    logic [CNT_W-1:0]              SkipCntOut;
    logic [CNT_W-1:0]              RedirectCntOut;

    modport master (
        output PredictedPCOut, PCValidOut, RetirePCOut, InFlightCntOut,
               SkipCntOut, RedirectCntOut,
        input  PCReadyIn, SkipTakenIn, SkipTargetIn, RedirectEnIn,
               RedirectPCIn, StallIn, RetireIn
    );

    modport slave (
        input  PredictedPCOut, PCValidOut, RetirePCOut, InFlightCntOut,
               SkipCntOut, RedirectCntOut,
        output PCReadyIn, SkipTakenIn, SkipTargetIn, RedirectEnIn,
               RedirectPCIn, StallIn, RetireIn
    );

endinterface

// File: rtl/pc_inflight_fifo.sv
// Small FIFO of outstanding fetch PCs. Depth must be a power of two so the
// pointers wrap naturally. Clear has priority over push and pop. The head
// output reads as zero while the FIFO is empty.
module pc_inflight_fifo
    import VSTypes::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  addr32b                   push_data,
    input  logic                     pop,
    output addr32b                   head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    addr32b           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; needs no reset because head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Front-end PC generator feeding the skip-table fetch stage.
// Next PC priority: redirect, then same-cycle skip target, then PC+4.
// Optional feature macro: PC_SEQ_STATS_EN enables the saturating skip and
// redirect counters; without it both counter outputs are tied to zero.
module pc_sequencer
    import VSTypes::*;
#(
    parameter addr32b RESET_PC       = 32'h0000_0000,
    parameter int     INFLIGHT_DEPTH = 4,
    parameter int     CNT_W          = 16
) (
    input  logic             ClockIn,
    input  logic             AsyncResetIn,
    pc_sequencer_if.master   bus
);

    localparam int CW = $clog2(INFLIGHT_DEPTH) + 1;

    PcSeqStateType  state;
    PcSeqStateType  state_next;
    addr32b         pc;
    addr32b         pc_next;
    logic           offer_valid;
    logic           transfer;
    logic           redirect_take;
    logic           push;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    addr32b         fifo_head;

    // State and current PC registers; reset discards everything in flight.
    always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
        if (!AsyncResetIn) begin
            state <= BOOT;
            pc    <= align_pc(RESET_PC);
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Next-state, offer-valid and next-PC selection; redirect overrides any transfer.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        offer_valid   = 1'b0;
        redirect_take = 1'b0;
        case (state)
            BOOT:    state_next = RUN;
            RUN: begin
                offer_valid = ~fifo_full;
                if (bus.StallIn) state_next = HOLD;
            end
            HOLD:    if (!bus.StallIn) state_next = RUN;
            FLUSH:   state_next = bus.StallIn ? HOLD : RUN;
            default: state_next = BOOT;
        endcase
        transfer = offer_valid & bus.PCReadyIn;
        if ((state != BOOT) && bus.RedirectEnIn) begin
            redirect_take = 1'b1;
            state_next    = FLUSH;
            pc_next       = align_pc(bus.RedirectPCIn);
        end else if (transfer) begin
            pc_next = bus.SkipTakenIn ? align_pc(bus.SkipTargetIn) : pc + PC_STEP;
        end
    end

    assign push = transfer & ~redirect_take;
    assign pop  = bus.RetireIn & ~fifo_empty & (state != FLUSH);

    pc_inflight_fifo #(
        .DEPTH (INFLIGHT_DEPTH)
    ) u_inflight (
        .clk       (ClockIn),
        .rst_n     (AsyncResetIn),
        .clear     (redirect_take),
        .push      (push),
        .push_data (pc),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.PredictedPCOut = pc;
    assign bus.PCValidOut     = offer_valid;
    assign bus.RetirePCOut    = fifo_head;
    assign bus.InFlightCntOut = fifo_count;

`ifdef PC_SEQ_STATS_EN
    logic [CNT_W-1:0] skip_cnt;
    logic [CNT_W-1:0] redirect_cnt;

    // Saturating counts of accepted skips and accepted redirects.
    always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
        if (!AsyncResetIn) begin
            skip_cnt     <= '0;
            redirect_cnt <= '0;
        end else begin
            if (push && bus.SkipTakenIn && (skip_cnt != '1))
                skip_cnt <= skip_cnt + 1'b1;
            if (redirect_take && (redirect_cnt != '1))
                redirect_cnt <= redirect_cnt + 1'b1;
        end
    end

    assign bus.SkipCntOut     = skip_cnt;
    assign bus.RedirectCntOut = redirect_cnt;
`else
    assign bus.SkipCntOut     = {CNT_W{1'b0}};
    assign bus.RedirectCntOut = {CNT_W{1'b0}};
`endif

endmodule
